sound_event_scheduler: RTL
==========================

SOUND_EVENT_SCHEDULER -- requirements
Module: sound_event_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms sound tick.
REQ-002 The block SHALL have parameters DUR_KILL 200, DUR_HIT 300, DUR_SHOT 80 and DUR_MOVE 30, each a playback length in ticks per event class.
REQ-003 The block SHALL have parameter GAP 10, the silent ticks between consecutive sounds.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have port ev_kill, input, 1 bit, enemy-destroyed event (level, rising edge counts).
REQ-007 The block SHALL have port ev_hit, input, 1 bit, player-hit event.
REQ-008 The block SHALL have port ev_shot, input, 1 bit, player-fire event.
REQ-009 The block SHALL have port ev_move, input, 1 bit, player-move event.
REQ-010 The block SHALL have port snd_code, output, 2 bits, selected sound: kill=3, hit=2, shot=1, move=0.
REQ-011 The block SHALL have port snd_start, output, 1 bit, a one-cycle pulse when a new sound is launched.
REQ-012 The block SHALL have port snd_active, output, 1 bit, high while a sound is playing.
REQ-013 The block SHALL have port pending, output, 4 bits, latched requests {kill,hit,shot,move}.
REQ-014 The block SHALL have port merge_cnt, output, 8 bits, saturating count of merged duplicate requests.

Function
REQ-015 The block SHALL register each ev_* input once and detect a rising edge as input=1 at cycle k with the registered value=0.
REQ-016 An edge at cycle k SHALL set the matching pending bit, visible at cycle k+1.
REQ-017 An edge on a class whose pending bit is already 1 SHALL leave the bit set and increment merge_cnt, saturating at 255.
REQ-018 The priority order SHALL be kill > hit > shot > move, and simultaneous edges SHALL set all the matching bits.
REQ-019 The FSM SHALL have the states IDLE, START, PLAY and GAP.
REQ-020 IDLE: if any pending bit is set, the FSM SHALL select the highest-priority one, clear that bit, load its duration and go to START the next cycle.
REQ-021 If a bit is cleared by selection and set by a new edge in the same cycle, the set SHALL win.
REQ-022 START SHALL last exactly 1 cycle with snd_start=1, SHALL clear the tick prescaler and duration counter, and SHALL then go to PLAY.
REQ-023 PLAY SHALL hold snd_active=1 for exactly DUR*TICK_DIV cycles and then go to GAP.
REQ-024 GAP SHALL hold snd_active=0 for exactly GAP*TICK_DIV cycles and then go to IDLE; if GAP=0, PLAY SHALL go directly to IDLE.
REQ-025 Preemption: in PLAY, a pending class of strictly higher priority than the current one SHALL abort the current sound (not requeued) and SHALL go to START on the next cycle with the new class, clearing its bit.
REQ-026 A pending class of equal or lower priority SHALL wait; GAP SHALL NOT be preempted.
REQ-027 snd_code SHALL equal the current class code in START and PLAY, and 0 otherwise.
REQ-028 The prescaler and duration counter SHALL run only in PLAY and GAP, and SHALL be sized for TICK_DIV and max(DUR,GAP) without wrap-around.

Reset
REQ-029 While reset=1, the block SHALL set state=IDLE, snd_code=0, snd_start=0, snd_active=0, pending=0, merge_cnt=0, clear the prescaler, counters and edge registers, and ignore events.
REQ-030 Reset mid-PLAY or mid-GAP SHALL silence output in the following cycle, with no pulse or request surviving.
REQ-031 An ev_* input held high through reset release SHALL NOT generate an event until it falls and rises again.

Verification (TICK_DIV=2, DUR_KILL=4, DUR_HIT=5, DUR_SHOT=3, DUR_MOVE=2, GAP=1)
REQ-032 Single shot edge at k: the bench SHALL check pending=0010 at k+1, snd_start=1 and snd_code=1 at k+2, snd_active=1 for cycles k+3..k+8, 0 for k+9..k+10, then IDLE.
REQ-033 Simultaneous shot+move edges: the bench SHALL check that shot plays first, move starts 1 cycle after shot's GAP ends with snd_code=0, and merge_cnt=0.
REQ-034 Shot playing, kill edge mid-PLAY: the bench SHALL check snd_start=1 and snd_code=3 two cycles after the edge, the shot is not replayed, and kill plays its full 8 cycles.
REQ-035 Three shot edges while a hit plays: the bench SHALL check pending=0010 and merge_cnt=2, then one shot plays after the hit finishes.
REQ-036 300 move edges with none played: the bench SHALL check that merge_cnt saturates at 255.
REQ-037 Reset asserted mid-PLAY with hit pending: the bench SHALL check all outputs are 0 the next cycle, with no snd_start after release until a new edge occurs.

Source files
------------

// File: rtl/sound_event_scheduler.sv
// Sound event scheduler.
// Latches game events (kill, hit, shot, move) as pending requests and plays
// them one at a time by priority kill > hit > shot > move. Each sound plays
// for a per-class number of 1 ms ticks, followed by a silent gap. A strictly
// higher-priority request aborts the sound that is playing. The gap cannot
// be aborted.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   ev_kill    enemy-destroyed event level (rising edge counts)
//   ev_hit     player-hit event level
//   ev_shot    player-fire event level
//   ev_move    player-move event level
//   snd_code   sound being launched or played: kill=3 hit=2 shot=1 move=0
//   snd_start  one-cycle pulse when a sound is launched
//   snd_active high while a sound is playing
//   pending    latched requests {kill,hit,shot,move}
//   merge_cnt  saturating count of requests merged into a pending one
module sound_event_scheduler #(
    parameter int TICK_DIV = 100000,
    parameter int DUR_KILL = 200,
    parameter int DUR_HIT  = 300,
    parameter int DUR_SHOT = 80,
    parameter int DUR_MOVE = 30,
    parameter int GAP      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ev_kill,
    input  logic       ev_hit,
    input  logic       ev_shot,
    input  logic       ev_move,
    output logic [1:0] snd_code,
    output logic       snd_start,
    output logic       snd_active,
    output logic [3:0] pending,
    output logic [7:0] merge_cnt
);

    localparam int MAX_A   = (DUR_KILL > DUR_HIT)  ? DUR_KILL : DUR_HIT;
    localparam int MAX_B   = (DUR_SHOT > DUR_MOVE) ? DUR_SHOT : DUR_MOVE;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_DUR = (MAX_C > GAP) ? MAX_C : GAP;
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW      = (MAX_DUR > 1) ? $clog2(MAX_DUR + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST   = DW'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_t;

    state_t        state;
    logic [3:0]    ev_now, ev_q, edge_v;
    logic [3:0]    clr, merge_hits;
    logic [1:0]    hi_code, cur;
    logic          take, tick_done;
    logic [PW-1:0] presc;
    logic [DW-1:0] tick_cnt, dur_len;
    logic [8:0]    merge_sum;
    logic [7:0]    merge_next;

    // Bit index of pending equals the class code.
    assign ev_now = {ev_kill, ev_hit, ev_shot, ev_move};
    assign edge_v = ev_now & ~ev_q;

    function automatic logic [DW-1:0] dur_of(input logic [1:0] c);
        case (c)
            2'd3:    return DW'(DUR_KILL);
            2'd2:    return DW'(DUR_HIT);
            2'd1:    return DW'(DUR_SHOT);
            default: return DW'(DUR_MOVE);
        endcase
    endfunction

    // Ascending scan: the last set bit is the highest priority.
    always_comb begin
        hi_code = 2'd0;
        for (int i = 0; i < 4; i++)
            if (pending[i]) hi_code = 2'(i);
    end

    assign take = (|pending) &&
                  ((state == S_IDLE) || (state == S_PLAY && hi_code > cur));
    assign clr  = take ? (4'b0001 << hi_code) : 4'b0000;

    // A request whose bit is being consumed this cycle is a fresh request,
    // not a duplicate, so it re-arms the bit without counting as a merge.
    assign merge_hits = edge_v & pending & ~clr;
    assign merge_sum  = {1'b0, merge_cnt} + 9'($countones(merge_hits));
    assign merge_next = merge_sum[8] ? 8'hFF : merge_sum[7:0];

    assign tick_done = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            snd_code   <= 2'd0;
            snd_start  <= 1'b0;
            snd_active <= 1'b0;
            pending    <= 4'd0;
            merge_cnt  <= 8'd0;
            presc      <= '0;
            tick_cnt   <= '0;
            dur_len    <= '0;
            cur        <= 2'd0;
            // Track the inputs so a level held across release is not an edge.
            ev_q       <= ev_now;
        end else begin
            ev_q      <= ev_now;
            pending   <= (pending & ~clr) | edge_v;
            merge_cnt <= merge_next;
            snd_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        cur       <= hi_code;
                        dur_len   <= dur_of(hi_code);
                        snd_code  <= hi_code;
                        snd_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    presc      <= '0;
                    tick_cnt   <= '0;
                    snd_active <= 1'b1;
                    state      <= S_PLAY;
                end
                S_PLAY: begin
                    if (take) begin
                        // Aborted sound is dropped, not requeued.
                        cur        <= hi_code;
                        dur_len    <= dur_of(hi_code);
                        snd_code   <= hi_code;
                        snd_start  <= 1'b1;
                        snd_active <= 1'b0;
                        state      <= S_START;
                    end else if (tick_done) begin
                        presc <= '0;
                        if (tick_cnt == dur_len - DW'(1)) begin
                            tick_cnt   <= '0;
                            snd_active <= 1'b0;
                            snd_code   <= 2'd0;
                            state      <= (GAP > 0) ? S_GAP : S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + DW'(1);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                S_GAP: begin
                    if (tick_done) begin
                        presc <= '0;
                        if (tick_cnt == GAP_LAST) begin
                            tick_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + DW'(1);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
